stream_demux: RTL and testbench

//   Registered 1-to-N demultiplexer for a valid/ready stream: the inverse of
//   the select mux. Each input beat is steered by in_sel into a one-entry

---
 rtl/stream_demux_if.sv | 30 +++
 rtl/stream_demux.sv | 79 +++++++
 tb/tb_stream_demux.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_demux_if.sv
// Stream bus for the 1-to-N demultiplexer: one producer-side valid/ready
// channel, N consumer-side lanes, and drop status.
interface stream_demux_if #(
  parameter int WIDTH = 8,
  parameter int N     = 3
);
  localparam int SELW = $clog2(N);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SELW-1:0]    in_sel;
  logic [N-1:0]       out_valid;
  logic [N-1:0]       out_ready;
  logic [N*WIDTH-1:0] out_data;
  logic               bad_sel;
  logic [7:0]         drop_cnt;

  // Producer plus consumers: drive the stream inputs, observe the demux outputs.
  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data, bad_sel, drop_cnt
  );

  // The demultiplexer itself.
  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data, bad_sel, drop_cnt
  );
endinterface

// File: rtl/stream_demux.sv
// Registered 1-to-N stream demultiplexer. Each accepted input beat lands in a
// one-entry slot on the lane chosen by in_sel; out-of-range selects are
// accepted, discarded and counted.
module stream_demux #(
  parameter int WIDTH = 8,
  parameter int N     = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  stream_demux_if.slave bus
);
  localparam int SELW = $clog2(N);

  logic [N-1:0]       r_out_valid;
  logic [N*WIDTH-1:0] r_out_data;
  logic               r_bad_sel;
  logic [7:0]         r_drop_cnt;

  logic [N-1:0]       w_hit;
  logic               w_blocked;
  logic               w_oob;
  logic               w_accept;
  logic [N-1:0]       w_push;
  logic               w_drop;

  // Decode the selected lane and whether its slot can take a beat this cycle.
  // An in_sel matching no lane leaves w_hit empty, so in_ready stays high.
  always_comb begin
    w_hit     = '0;
    w_blocked = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (bus.in_sel == SELW'(k)) begin
        w_hit[k]  = 1'b1;
        w_blocked = r_out_valid[k] & ~bus.out_ready[k];
      end
    end
  end

  assign w_oob    = ~|w_hit;
  assign w_accept = bus.in_valid & ~w_blocked;
  assign w_push   = {N{w_accept}} & w_hit;
  assign w_drop   = bus.in_valid & w_oob;

  // Lane slots: a push reloads the slot (even while it pops); a pop alone empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= '0;
      r_out_data  <= '0;
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        if (w_push[k]) begin
          r_out_valid[k]                 <= 1'b1;
          r_out_data[k*WIDTH +: WIDTH]   <= bus.in_data;
        end else if (bus.out_ready[k]) begin
          r_out_valid[k]                 <= 1'b0;
        end
      end
    end
  end

  // Drop reporting: one-cycle pulse plus a saturating counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bad_sel  <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_bad_sel <= w_drop;
      if (w_drop && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  assign bus.in_ready  = ~w_blocked;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.bad_sel   = r_bad_sel;
  assign bus.drop_cnt  = r_drop_cnt;
endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux (WIDTH=8, N=3).
module tb_stream_demux;
  localparam int WIDTH = 8;
  localparam int N     = 3;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  stream_demux_if #(.WIDTH(WIDTH), .N(N)) bus ();

  stream_demux #(.WIDTH(WIDTH), .N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] lane(input int k);
    return bus.out_data[k*WIDTH +: WIDTH];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_sel    = '0;
    bus.out_ready = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (bus.out_valid !== 3'b000) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=000", bus.out_valid); end
    n_checks++;
    if (bus.out_data !== 24'h0) begin n_fail++; $display("FAIL reset_out_data got=%h exp=000000", bus.out_data); end
    n_checks++;
    if (bus.bad_sel !== 1'b0) begin n_fail++; $display("FAIL reset_bad_sel got=%b exp=0", bus.bad_sel); end
    n_checks++;
    if (bus.drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop_cnt got=%0d exp=0", bus.drop_cnt); end
  endtask

  task automatic test_hold_pop();
    bus.in_valid = 1'b1; bus.in_sel = 2'd1; bus.in_data = 8'hA5; bus.out_ready = 3'b000;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_in_ready got=%b exp=1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (bus.out_valid !== 3'b010 || lane(1) !== 8'hA5) begin
        n_fail++; $display("FAIL hold_lane1 cyc=%0d got=%b/%h exp=010/a5", i, bus.out_valid, lane(1));
      end
      if (i < 5) tick();
    end
    bus.out_ready = 3'b010;
    tick();
    bus.out_ready = 3'b000;
    n_checks++;
    if (bus.out_valid !== 3'b000) begin n_fail++; $display("FAIL pop_lane1 got=%b exp=000", bus.out_valid); end
    n_checks++;
    if (lane(1) !== 8'hA5) begin n_fail++; $display("FAIL pop_keeps_data got=%h exp=a5", lane(1)); end
  endtask

  task automatic test_backpressure();
    bus.in_valid = 1'b1; bus.in_sel = 2'd2; bus.in_data = 8'h3C; bus.out_ready = 3'b000;
    tick();
    bus.in_data = 8'h99;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got=%b exp=0", bus.in_ready); end
    tick();
    n_checks++;
    if (bus.out_valid !== 3'b100 || lane(2) !== 8'h3C) begin
      n_fail++; $display("FAIL bp_lane2_held got=%b/%h exp=100/3c", bus.out_valid, lane(2));
    end
    bus.in_sel = 2'd0; bus.in_data = 8'h77;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_other_lane_ready got=%b exp=1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 3'b101 || lane(0) !== 8'h77 || lane(2) !== 8'h3C) begin
      n_fail++; $display("FAIL bp_lane0_load got=%b/%h/%h exp=101/77/3c", bus.out_valid, lane(0), lane(2));
    end
    bus.out_ready = 3'b111;
    tick();
    bus.out_ready = 3'b000;
    n_checks++;
    if (bus.out_valid !== 3'b000) begin n_fail++; $display("FAIL bp_drain got=%b exp=000", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 3'b001;
    bus.in_sel    = 2'd0;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h10 + 8'(i);
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready beat=%0d got=%b exp=1", i, bus.in_ready); end
      tick();
      n_checks++;
      if (bus.out_valid[0] !== 1'b1 || lane(0) !== 8'h10 + 8'(i)) begin
        n_fail++; $display("FAIL b2b_lane0 beat=%0d got=%b/%h exp=1/%h", i, bus.out_valid[0], lane(0), 8'h10 + 8'(i));
      end
    end
    bus.in_valid = 1'b0;
    tick();
    bus.out_ready = 3'b000;
    n_checks++;
    if (bus.out_valid !== 3'b000) begin n_fail++; $display("FAIL b2b_drain got=%b exp=000", bus.out_valid); end
  endtask

  task automatic test_bad_sel();
    int exp_cnt;
    bus.in_valid = 1'b1; bus.in_sel = 2'd1; bus.in_data = 8'h42; bus.out_ready = 3'b000;
    tick();
    bus.in_sel = 2'd3; bus.in_data = 8'hFF;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bad_in_ready got=%b exp=1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 3'b010 || lane(1) !== 8'h42) begin
      n_fail++; $display("FAIL bad_lanes_unchanged got=%b/%h exp=010/42", bus.out_valid, lane(1));
    end
    n_checks++;
    if (bus.bad_sel !== 1'b1 || bus.drop_cnt !== 8'd1) begin
      n_fail++; $display("FAIL bad_pulse got=%b/%0d exp=1/1", bus.bad_sel, bus.drop_cnt);
    end
    tick();
    n_checks++;
    if (bus.bad_sel !== 1'b0 || bus.drop_cnt !== 8'd1) begin
      n_fail++; $display("FAIL bad_pulse_end got=%b/%0d exp=0/1", bus.bad_sel, bus.drop_cnt);
    end
    exp_cnt = 1;
    for (int i = 0; i < 300; i++) begin
      bus.in_valid = 1'b1; bus.in_sel = 2'd3; bus.in_data = 8'($urandom);
      tick();
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      n_checks++;
      if (bus.bad_sel !== 1'b1 || bus.drop_cnt !== 8'(exp_cnt)) begin
        n_fail++; $display("FAIL bad_sat i=%0d got=%b/%0d exp=1/%0d", i, bus.bad_sel, bus.drop_cnt, exp_cnt);
      end
    end
    bus.in_valid = 1'b0;
    tick();
    n_checks++;
    if (bus.bad_sel !== 1'b0 || bus.drop_cnt !== 8'd255 || bus.out_valid !== 3'b010) begin
      n_fail++; $display("FAIL bad_final got=%b/%0d/%b exp=0/255/010", bus.bad_sel, bus.drop_cnt, bus.out_valid);
    end
  endtask

  task automatic test_async_reset();
    bus.out_ready = 3'b000;
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1; bus.in_sel = 2'(k); bus.in_data = 8'hC0 + 8'(k);
      tick();
    end
    bus.in_valid = 1'b1; bus.in_sel = 2'd3;
    tick();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 3'b111 || bus.bad_sel !== 1'b1) begin
      n_fail++; $display("FAIL ar_prefill got=%b/%b exp=111/1", bus.out_valid, bus.bad_sel);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 3'b000 || bus.drop_cnt !== 8'd0 || bus.bad_sel !== 1'b0 || bus.out_data !== 24'h0) begin
      n_fail++; $display("FAIL ar_immediate got=%b/%0d/%b/%h exp=000/0/0/000000",
                         bus.out_valid, bus.drop_cnt, bus.bad_sel, bus.out_data);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    bus.in_valid = 1'b1; bus.in_sel = 2'd1; bus.in_data = 8'h5A;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL ar_post_ready got=%b exp=1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 3'b010 || lane(1) !== 8'h5A) begin
      n_fail++; $display("FAIL ar_post_push got=%b/%h exp=010/5a", bus.out_valid, lane(1));
    end
  endtask

  task automatic test_random();
    logic [7:0] q[3][$];
    int         drops;
    logic       exp_bad;
    logic       exp_ready;
    logic       v;
    logic [1:0] s;
    logic [7:0] d;
    logic [2:0] r;
    do_reset();
    drops   = 0;
    exp_bad = 1'b0;
    for (int cyc = 0; cyc < 10010; cyc++) begin
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (bus.out_valid[k] !== (q[k].size() > 0)) begin
          n_fail++; $display("FAIL rnd_valid cyc=%0d lane=%0d got=%b exp=%b", cyc, k, bus.out_valid[k], q[k].size() > 0);
        end else if (q[k].size() > 0) begin
          n_checks++;
          if (lane(k) !== q[k][0]) begin
            n_fail++; $display("FAIL rnd_data cyc=%0d lane=%0d got=%h exp=%h", cyc, k, lane(k), q[k][0]);
          end
        end
      end
      n_checks++;
      if (bus.bad_sel !== exp_bad || bus.drop_cnt !== 8'((drops > 255) ? 255 : drops)) begin
        n_fail++; $display("FAIL rnd_drop cyc=%0d got=%b/%0d exp=%b/%0d", cyc, bus.bad_sel, bus.drop_cnt,
                           exp_bad, (drops > 255) ? 255 : drops);
      end
      if (cyc < 10000) begin
        v = ($urandom_range(0, 3) != 0);
        s = 2'($urandom_range(0, 3));
        d = 8'($urandom);
        r = 3'($urandom);
      end else begin
        v = 1'b0; s = 2'd0; d = 8'h00; r = 3'b111;
      end
      bus.in_valid = v; bus.in_sel = s; bus.in_data = d; bus.out_ready = r;
      #1;
      exp_ready = (s == 2'd3) || (q[s].size() == 0) || r[s];
      n_checks++;
      if (bus.in_ready !== exp_ready) begin
        n_fail++; $display("FAIL rnd_in_ready cyc=%0d sel=%0d got=%b exp=%b", cyc, s, bus.in_ready, exp_ready);
      end
      for (int k = 0; k < 3; k++) begin
        if (q[k].size() > 0 && r[k]) void'(q[k].pop_front());
      end
      exp_bad = v && (s == 2'd3);
      if (v && exp_ready) begin
        if (s == 2'd3) drops++;
        else q[s].push_back(d);
      end
      tick();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 3'b000;
    n_checks++;
    if (q[0].size() + q[1].size() + q[2].size() != 0 || bus.out_valid !== 3'b000) begin
      n_fail++; $display("FAIL rnd_drained got=%b exp=000", bus.out_valid);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    idle_inputs();
    test_reset();
    test_hold_pop();
    test_backpressure();
    test_back_to_back();
    test_bad_sel();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
